// File: rtl/nn_axis_tx.sv
// nn_axis_tx: AXI-Stream master for the network result vector.
// A parallel vector of NUM_OUT words is captured on a one-cycle strobe and
// sent lowest word first, with tlast on the final word. One further vector
// can wait in a pending buffer; any vector beyond that is dropped and counted.
module nn_axis_tx #(
  parameter int NUM_OUT        = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                          s_axi_aclk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic [NUM_OUT*DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [DROP_CNT_WIDTH-1:0]     o_drop_count
);

  localparam int VW = NUM_OUT * DATA_WIDTH;
  localparam int CW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OUT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state;
  logic [VW-1:0]             active;
  logic [CW-1:0]             count;
  logic [VW-1:0]             pending;
  logic                      pend_full;
  logic                      done_q;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  logic beat;
  logic final_beat;

  // The word on the bus is always the low slice of the active register, so it
  // stays stable under backpressure without any extra holding logic.
  assign m_axis_tdata  = active[DATA_WIDTH-1:0];
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tlast  = (state == SEND) && (count == LAST_IDX);
  assign o_busy        = (state == SEND) || pend_full;
  assign o_done        = done_q;
  assign o_drop_count  = drop_count;

  assign beat       = (state == SEND) && m_axis_tready;
  assign final_beat = beat && (count == LAST_IDX);

  // Sequencer: load/shift the active vector, manage the pending slot and drops.
  // NOTE: every flop here uses <= so all updates see the pre-edge values; a
  // blocking '=' would let later statements read already-updated state.
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state      <= IDLE;
      active     <= '0;
      count      <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      done_q     <= 1'b0;
      drop_count <= '0;
    end else begin
      done_q <= final_beat;
      case (state)
        IDLE: begin
          // The pending slot is always empty here: SEND only falls back to
          // IDLE when nothing is waiting.
          if (i_valid) begin
            active <= i_data;
            count  <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (final_beat) begin
            if (pend_full) begin
              // Back-to-back: pending becomes active; a new arrival refills it.
              active <= pending;
              count  <= '0;
              if (i_valid) pending   <= i_data;
              else         pend_full <= 1'b0;
            end else if (i_valid) begin
              active <= i_data;
              count  <= '0;
            end else begin
              active <= active >> DATA_WIDTH;
              count  <= '0;
              state  <= IDLE;
            end
          end else begin
            if (beat) begin
              active <= active >> DATA_WIDTH;
              count  <= count + CW'(1);
            end
            if (i_valid) begin
              if (!pend_full) begin
                pending   <= i_data;
                pend_full <= 1'b1;
              end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
